// File: rtl/ram_arbiter_pkg.sv
// ============================================================
// ram_arbiter_pkg : shared widths, FSM states and port indices
// Rev 1.0
// ============================================================
`default_nettype none

package ram_arbiter_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 4;
    localparam int RAM_DW   = 16;
    localparam int NPORTS   = 2;

    localparam logic PORT_LOADER = 1'b0;
    localparam logic PORT_CPU    = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================
// ram_arbiter_if : requester ports plus RAM command/data bus
// Rev 1.0
// ============================================================
`default_nettype none

interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              valid0;
    logic              valid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [RAM_DW-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, valid0, valid1, rdata0, rdata1, busy,
               ram_we, ram_addr, ram_wdata
    );

    // Requesters and RAM side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, valid0, valid1, rdata0, rdata1, busy,
               ram_we, ram_addr, ram_wdata
    );

endinterface

`default_nettype wire

// File: rtl/ram_arb_rr.sv
// ============================================================
// ram_arb_rr : two-way round-robin / fixed-priority picker
// Rev 1.0
// ============================================================
`default_nettype none

module ram_arb_rr
    import ram_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  wire logic [1:0] req,
    input  wire logic       last,
    output logic      [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            // Tie: fixed mode favours the loader, otherwise whoever did not win last
            2'b11: grant = ((FIXED_PRIORITY != 0) || (last == PORT_CPU)) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================
// ram_arbiter : shares the 16x4 data RAM between loader and CPU
// Rev 1.0
// ============================================================
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    ram_arbiter_if.slave bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic [1:0]        w_req;
    logic [1:0]        w_win;
    logic              w_win_port;

    logic              r_last;
    logic              r_cur_port;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [1:0]        r_gnt;
    logic [1:0]        r_valid;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_unused_rdata_hi;

    assign w_req             = {bus.req1, bus.req0};
    assign w_win_port        = w_win[1];
    assign w_unused_rdata_hi = ^bus.ram_rdata[RAM_DW-1:DATA_W];

    ram_arb_rr #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_pick (
        .req   (w_req),
        .last  (r_last),
        .grant (w_win)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_accept     = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            // r_ram_we is the latched command type for the access in flight
            ACCESS:  w_state_next = r_ram_we ? IDLE : CAPTURE;
            CAPTURE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= PORT_CPU;
            r_cur_port  <= PORT_LOADER;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_gnt       <= 2'b00;
            r_valid     <= 2'b00;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_gnt    <= 2'b00;
            r_valid  <= 2'b00;
            r_ram_we <= 1'b0;
            if (w_accept) begin
                r_gnt       <= w_win;
                r_cur_port  <= w_win_port;
                r_last      <= w_win_port;
                r_ram_we    <= w_win_port ? bus.we1    : bus.we0;
                r_ram_addr  <= w_win_port ? bus.addr1  : bus.addr0;
                r_ram_wdata <= w_win_port ? bus.wdata1 : bus.wdata0;
            end
            // The RAM's registered read output is valid during CAPTURE
            if (r_state == CAPTURE) begin
                if (r_cur_port == PORT_CPU) begin
                    r_valid[1] <= 1'b1;
                    r_rdata1   <= bus.ram_rdata[DATA_W-1:0];
                end else begin
                    r_valid[0] <= 1'b1;
                    r_rdata0   <= bus.ram_rdata[DATA_W-1:0];
                end
            end
        end
    end

    assign bus.gnt0      = r_gnt[0];
    assign bus.gnt1      = r_gnt[1];
    assign bus.valid0    = r_valid[0];
    assign bus.valid1    = r_valid[1];
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.busy      = (r_state != IDLE);
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================
// tb_ram_arbiter : directed bench for ram_arbiter with a 16x4 RAM model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ram_arbiter_if bus_rr ();
    ram_arbiter_if bus_fp ();

    ram_arbiter #(.FIXED_PRIORITY(0)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    ram_arbiter #(.FIXED_PRIORITY(1)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read, not reset
    logic [3:0]  mem [16];
    logic [3:0]  ram_q = 4'h0;
    logic [11:0] ram_hi = 12'h000;
    assign bus_rr.ram_rdata = {ram_hi, ram_q};
    assign bus_fp.ram_rdata = 16'h0000;

    always @(posedge clk) begin
        if (bus_rr.ram_we) mem[bus_rr.ram_addr] <= bus_rr.ram_wdata;
        ram_q <= mem[bus_rr.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nval;
        int nxt;
        int last_c;
        int ng;
        int fp0;
        int fp1;
        int g0cnt;

        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        bus_rr.req0 = 0; bus_rr.req1 = 0; bus_rr.we0 = 0; bus_rr.we1 = 0;
        bus_rr.addr0 = 0; bus_rr.addr1 = 0; bus_rr.wdata0 = 0; bus_rr.wdata1 = 0;
        bus_fp.req0 = 0; bus_fp.req1 = 0; bus_fp.we0 = 0; bus_fp.we1 = 0;
        bus_fp.addr0 = 0; bus_fp.addr1 = 0; bus_fp.wdata0 = 0; bus_fp.wdata1 = 0;

        tick(); tick();
        rst = 0;
        chk("reset_ctl", {bus_rr.gnt0, bus_rr.gnt1, bus_rr.valid0, bus_rr.valid1, bus_rr.busy, bus_rr.ram_we}, 0);
        chk("reset_data", {bus_rr.rdata0, bus_rr.rdata1, bus_rr.ram_addr, bus_rr.ram_wdata}, 0);

        // Port 0 writes 0xA to address 3
        bus_rr.req0 = 1; bus_rr.we0 = 1; bus_rr.addr0 = 4'd3; bus_rr.wdata0 = 4'hA;
        tick();
        chk("wr_gnt0", {bus_rr.gnt0, bus_rr.gnt1}, 2'b10);
        chk("wr_cmd", {bus_rr.ram_we, bus_rr.ram_addr, bus_rr.ram_wdata, bus_rr.busy}, {1'b1, 4'd3, 4'hA, 1'b1});
        bus_rr.req0 = 0;
        tick();
        chk("wr_done", {bus_rr.ram_we, bus_rr.busy, bus_rr.gnt0}, 3'b000);

        // Port 1 reads address 3
        bus_rr.req1 = 1; bus_rr.we1 = 0; bus_rr.addr1 = 4'd3;
        tick();
        chk("rd_gnt1", {bus_rr.gnt0, bus_rr.gnt1, bus_rr.ram_we, bus_rr.busy}, 4'b0101);
        bus_rr.req1 = 0;
        tick();
        chk("rd_capture", {bus_rr.busy, bus_rr.valid1}, 2'b10);
        tick();
        chk("rd_valid", {bus_rr.valid1, bus_rr.rdata1, bus_rr.rdata0, bus_rr.busy}, {1'b1, 4'hA, 4'h0, 1'b0});
        tick();
        chk("rd_hold", {bus_rr.valid1, bus_rr.rdata1}, {1'b0, 4'hA});

        // Loader fill: mem[i] = i
        g0cnt = 0;
        for (int i = 0; i < 16; i++) begin
            bus_rr.req0 = 1; bus_rr.we0 = 1; bus_rr.addr0 = 4'(i); bus_rr.wdata0 = 4'(i);
            tick();
            if (bus_rr.gnt0) g0cnt++;
            bus_rr.req0 = 0;
            tick();
        end
        chk("fill_grants", g0cnt, 16);

        // Back-to-back reads of 0..15 by the CPU port
        bus_rr.req1 = 1; bus_rr.we1 = 0; bus_rr.addr1 = 4'd0;
        nxt = 1; nval = 0; last_c = 0;
        for (int c = 0; c < 80 && nval < 16; c++) begin
            tick();
            if (bus_rr.gnt1) begin
                if (nxt < 16) begin
                    bus_rr.addr1 = 4'(nxt);
                    nxt++;
                end else begin
                    bus_rr.req1 = 0;
                end
            end
            if (bus_rr.valid1) begin
                chk("sweep_rdata", bus_rr.rdata1, nval);
                if (nval > 0) chk("sweep_spacing", c - last_c, 3);
                last_c = c;
                nval++;
            end
        end
        bus_rr.req1 = 0;
        chk("sweep_count", nval, 16);

        // Upper RAM bits must be ignored
        ram_hi = 12'hFFF;
        bus_rr.req1 = 1; bus_rr.addr1 = 4'd5;
        tick();
        bus_rr.req1 = 0;
        tick(); tick();
        chk("hi_bits", {bus_rr.valid1, bus_rr.rdata1}, {1'b1, 4'h5});
        ram_hi = 12'h000;

        // Reset while in CAPTURE
        bus_rr.req0 = 1; bus_rr.we0 = 0; bus_rr.addr0 = 4'd3;
        tick();
        chk("mr_gnt0", bus_rr.gnt0, 1'b1);
        bus_rr.req0 = 0;
        tick();
        chk("mr_capture", bus_rr.busy, 1'b1);
        rst = 1;
        tick();
        chk("mr_reset_ctl", {bus_rr.gnt0, bus_rr.gnt1, bus_rr.valid0, bus_rr.valid1, bus_rr.busy, bus_rr.ram_we}, 0);
        chk("mr_reset_data", {bus_rr.rdata0, bus_rr.rdata1, bus_rr.ram_addr, bus_rr.ram_wdata}, 0);
        rst = 0;
        tick();
        chk("mr_no_valid", {bus_rr.valid0, bus_rr.rdata0}, 0);

        // Both ports writing continuously: round-robin vs fixed priority
        bus_rr.req0 = 1; bus_rr.we0 = 1; bus_rr.addr0 = 4'd4; bus_rr.wdata0 = 4'd4;
        bus_rr.req1 = 1; bus_rr.we1 = 1; bus_rr.addr1 = 4'd5; bus_rr.wdata1 = 4'd5;
        bus_fp.req0 = 1; bus_fp.we0 = 1; bus_fp.addr0 = 4'd1; bus_fp.wdata0 = 4'd1;
        bus_fp.req1 = 1; bus_fp.we1 = 1; bus_fp.addr1 = 4'd2; bus_fp.wdata1 = 4'd2;
        ng = 0; fp0 = 0; fp1 = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            tick();
            if (bus_fp.gnt0) fp0++;
            if (bus_fp.gnt1) fp1++;
            if (bus_rr.gnt0 || bus_rr.gnt1) begin
                chk("rr_order", {bus_rr.gnt1, bus_rr.gnt0}, (ng % 2 == 0) ? 2'b01 : 2'b10);
                ng++;
            end
        end
        bus_rr.req0 = 0; bus_rr.req1 = 0; bus_fp.req0 = 0; bus_fp.req1 = 0;
        chk("rr_grants", ng, 4);
        chk("fp_port0_grants", fp0, 4);
        chk("fp_port1_grants", fp1, 0);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
